// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if
// Bundles the two handshakes of the instruction-fetch stage:
//   - instruction-memory request/grant/return bus (imem_*)
//   - IF/ID slot toward decode (id_*), valid/ready
// Modports:
//   master : the fetch stage (drives imem request and the IF/ID slot)
//   slave  : the environment (memory and decode side)
// Optional member id_exc_o exists only when IF_MISALIGN_CHECK_EN is defined.
// ---------------------------------------------------------------------------
interface if_fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc4_o;
  logic [31:0] id_inst_o;
`ifdef IF_MISALIGN_CHECK_EN
  logic        id_exc_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output id_valid_o, id_pc_o, id_pc4_o, id_inst_o, id_exc_o,
    input  id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  id_valid_o, id_pc_o, id_pc4_o, id_inst_o, id_exc_o,
    output id_ready_i
  );
`else
  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output id_valid_o, id_pc_o, id_pc4_o, id_inst_o,
    input  id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  id_valid_o, id_pc_o, id_pc4_o, id_inst_o,
    output id_ready_i
  );
`endif
endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage sitting behind the 32-bit PC register. Issues one
// instruction-memory request at a time for the registered PC, pulses the PC
// register enable when the request is granted, and places the returned word
// into the IF/ID slot. A one-entry hold buffer absorbs a return that arrives
// while decode is stalled; flush_i kills in-flight and buffered instructions.
//
// Ports:
//   clk      rising-edge clock
//   clr      synchronous reset, active-high
//   pc_i     current PC from the PC register
//   pc_en_o  PC register enable (sequential advance only), same cycle as grant
//   flush_i  redirect; kills slot, hold buffer and any in-flight return
//   bus      if_fetch_if.master: imem_* request bus and id_* slot to decode
//
// Optional feature (macro IF_MISALIGN_CHECK_EN): a misaligned pc_i is never
// fetched; instead the slot is loaded with a NOP carrying id_exc_o=1 and the
// stage parks in REQ until a flush redirects it. With the macro undefined
// there is no id_exc_o and pc_i[1:0] is simply dropped from the address.
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc_i,
  output logic        pc_en_o,
  input  logic        flush_i,
  if_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Modulo-2^32 successor address of a slot PC.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  state_t      state_r;
  logic [31:0] pend_pc_r;    // PC of the request currently outstanding / held
  logic [31:0] hold_inst_r;  // returned word parked while decode stalls
  logic        hold_vld_r;
  logic        drop_r;       // next return belongs to a flushed request

  logic        id_valid_r;
  logic [31:0] id_pc_r;
  logic [31:0] id_pc4_r;
  logic [31:0] id_inst_r;
`ifdef IF_MISALIGN_CHECK_EN
  logic        id_exc_r;
`endif

  logic        req_s;
  logic        slot_free_s;
  logic        misalign_s;

`ifdef IF_MISALIGN_CHECK_EN
  assign misalign_s = (pc_i[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // Request is only raised in REQ, and never on a flush or misaligned PC.
  always_comb begin
    req_s = 1'b0;
    if (state_r == S_REQ) begin
      req_s = ~flush_i & ~misalign_s;
    end else begin
      req_s = 1'b0;
    end
  end

  // A slot accepts new data if it is empty or being consumed this cycle.
  assign slot_free_s     = ~id_valid_r | bus.id_ready_i;

  assign bus.imem_req_o  = req_s;
  assign bus.imem_addr_o = {pc_i[31:2], 2'b00};
  // Grant while not requesting is ignored because req_s gates it.
  assign pc_en_o         = req_s & bus.imem_gnt_i;

  assign bus.id_valid_o  = id_valid_r;
  assign bus.id_pc_o     = id_pc_r;
  assign bus.id_pc4_o    = id_pc4_r;
  assign bus.id_inst_o   = id_inst_r;
`ifdef IF_MISALIGN_CHECK_EN
  assign bus.id_exc_o    = id_exc_r;
`endif

  // Fetch FSM, hold buffer and IF/ID slot registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r     <= S_REQ;
      pend_pc_r   <= 32'h0000_0000;
      hold_inst_r <= NOP_INST;
      hold_vld_r  <= 1'b0;
      drop_r      <= 1'b0;
      id_valid_r  <= 1'b0;
      id_pc_r     <= 32'h0000_0000;
      id_pc4_r    <= PC_STEP;
      id_inst_r   <= NOP_INST;
`ifdef IF_MISALIGN_CHECK_EN
      id_exc_r    <= 1'b0;
`endif
    end else begin
      // Consumption empties the slot; a same-cycle load below overrides it.
      if (id_valid_r && bus.id_ready_i) begin
        id_valid_r <= 1'b0;
        id_inst_r  <= NOP_INST;
`ifdef IF_MISALIGN_CHECK_EN
        id_exc_r   <= 1'b0;
`endif
      end

      if (flush_i) begin
        // Flush outranks every other event this cycle.
        id_valid_r  <= 1'b0;
        id_inst_r   <= NOP_INST;
        hold_vld_r  <= 1'b0;
        hold_inst_r <= NOP_INST;
`ifdef IF_MISALIGN_CHECK_EN
        id_exc_r    <= 1'b0;
`endif
        case (state_r)
          S_REQ: begin
            state_r <= S_REQ;
          end
          S_WAIT: begin
            if (bus.imem_rvalid_i) begin
              // The return is the flushed word itself; nothing left to drop.
              drop_r  <= 1'b0;
              state_r <= S_REQ;
            end else begin
              drop_r  <= 1'b1;
              state_r <= S_WAIT;
            end
          end
          S_HOLD: begin
            state_r <= S_REQ;
          end
          default: begin
            drop_r  <= 1'b0;
            state_r <= S_REQ;
          end
        endcase
      end else begin
        case (state_r)
          S_REQ: begin
            if (misalign_s) begin
              if (slot_free_s) begin
                id_valid_r <= 1'b1;
                id_pc_r    <= pc_i;
                id_pc4_r   <= next_pc(pc_i);
                id_inst_r  <= NOP_INST;
`ifdef IF_MISALIGN_CHECK_EN
                id_exc_r   <= 1'b1;
`endif
              end
              state_r <= S_REQ;
            end else if (req_s && bus.imem_gnt_i) begin
              pend_pc_r <= pc_i;
              state_r   <= S_WAIT;
            end else begin
              state_r <= S_REQ;
            end
          end
          S_WAIT: begin
            if (!bus.imem_rvalid_i) begin
              state_r <= S_WAIT;
            end else if (drop_r) begin
              drop_r  <= 1'b0;
              state_r <= S_REQ;
            end else if (slot_free_s) begin
              id_valid_r <= 1'b1;
              id_pc_r    <= pend_pc_r;
              id_pc4_r   <= next_pc(pend_pc_r);
              id_inst_r  <= bus.imem_rdata_i;
`ifdef IF_MISALIGN_CHECK_EN
              id_exc_r   <= 1'b0;
`endif
              state_r    <= S_REQ;
            end else begin
              hold_inst_r <= bus.imem_rdata_i;
              hold_vld_r  <= 1'b1;
              state_r     <= S_HOLD;
            end
          end
          S_HOLD: begin
            // Slot is known valid here, so ready means it drains this cycle.
            if (bus.id_ready_i && hold_vld_r) begin
              id_valid_r  <= 1'b1;
              id_pc_r     <= pend_pc_r;
              id_pc4_r    <= next_pc(pend_pc_r);
              id_inst_r   <= hold_inst_r;
`ifdef IF_MISALIGN_CHECK_EN
              id_exc_r    <= 1'b0;
`endif
              hold_vld_r  <= 1'b0;
              state_r     <= S_REQ;
            end else if (!hold_vld_r) begin
              state_r <= S_REQ;
            end else begin
              state_r <= S_HOLD;
            end
          end
          default: begin
            drop_r  <= 1'b0;
            state_r <= S_REQ;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
// Directed steps for reset, single fetch, hold under back-pressure, flush
// cases, mid-transaction reset, PC wrap and the misalignment option, then a
// randomized phase checked against a transaction-level model: every granted
// address must later appear at decode, in order, carrying the memory word.
// ---------------------------------------------------------------------------
module tb_if_fetch;
  logic        clk;
  logic        clr;
  logic [31:0] pc_i;
  logic        pc_en_o;
  logic        flush_i;

  if_fetch_if bus();

  if_fetch dut (
    .clk     (clk),
    .clr     (clr),
    .pc_i    (pc_i),
    .pc_en_o (pc_en_o),
    .flush_i (flush_i),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        expq[$];
  ent_t        e;
  logic [31:0] pcreg;
  logic [31:0] oaddr;
  bit          outst;
  int          dly;
  int          consumed;
  bit          drain;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ a[15:0]};
  endfunction

  initial begin
    clk = 1'b0;
    clr = 1'b1;
    pc_i = 32'h0;
    flush_i = 1'b0;
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = 32'h0;
    bus.id_ready_i = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    chk("rst_valid", bus.id_valid_o, 1'b0);
    chk("rst_inst", bus.id_inst_o, 32'h0000_0000);
    chk("rst_pc", bus.id_pc_o, 32'h0000_0000);
    chk("rst_pc4", bus.id_pc4_o, 32'h0000_0004);
`ifdef IF_MISALIGN_CHECK_EN
    chk("rst_exc", bus.id_exc_o, 1'b0);
`endif

    // Single fetch: grant in cycle 0, data next cycle, slot one cycle later.
    pc_i = 32'h0; bus.imem_gnt_i = 1'b1; bus.id_ready_i = 1'b1;
    #1;
    chk("t1_req", bus.imem_req_o, 1'b1);
    chk("t1_addr", bus.imem_addr_o, 32'h0);
    chk("t1_pc_en", pc_en_o, 1'b1);
    tick();
    pc_i = 32'h4; bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h2008_0005;
    #1;
    chk("t1_wait_req", bus.imem_req_o, 1'b0);
    chk("t1_wait_pc_en", pc_en_o, 1'b0);
    tick();
    bus.imem_rvalid_i = 1'b0;
    chk("t1_valid", bus.id_valid_o, 1'b1);
    chk("t1_pc", bus.id_pc_o, 32'h0);
    chk("t1_pc4", bus.id_pc4_o, 32'h4);
    chk("t1_inst", bus.id_inst_o, 32'h2008_0005);

    // Second fetch returns while decode stalls: parked in the hold buffer.
    bus.id_ready_i = 1'b0; bus.imem_gnt_i = 1'b1;
    #1;
    chk("t2_pc_en", pc_en_o, 1'b1);
    tick();
    pc_i = 32'h8; bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h1111_2222;
    tick();
    bus.imem_rvalid_i = 1'b0; bus.imem_gnt_i = 1'b1;
    #1;
    chk("t2_hold_inst", bus.id_inst_o, 32'h2008_0005);
    chk("t2_hold_req", bus.imem_req_o, 1'b0);
    chk("t2_hold_pc_en", pc_en_o, 1'b0);
    tick();
    chk("t2_hold2_req", bus.imem_req_o, 1'b0);
    bus.imem_gnt_i = 1'b0; bus.id_ready_i = 1'b1;
    tick();
    chk("t2_valid", bus.id_valid_o, 1'b1);
    chk("t2_pc", bus.id_pc_o, 32'h4);
    chk("t2_pc4", bus.id_pc4_o, 32'h8);
    chk("t2_inst", bus.id_inst_o, 32'h1111_2222);
    chk("t2_req_again", bus.imem_req_o, 1'b1);

    // Flush in WAIT before the return; the late word must be dropped.
    bus.imem_gnt_i = 1'b1;
    tick();
    pc_i = 32'hC; bus.imem_gnt_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t3_valid_flush", bus.id_valid_o, 1'b0);
    tick();
    tick();
    pc_i = 32'h100; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid_i = 1'b0;
    chk("t3_valid_drop", bus.id_valid_o, 1'b0);
    chk("t3_inst_drop", bus.id_inst_o, 32'h0);
    bus.imem_gnt_i = 1'b1;
    #1;
    chk("t3_req", bus.imem_req_o, 1'b1);
    chk("t3_addr", bus.imem_addr_o, 32'h100);
    chk("t3_pc_en", pc_en_o, 1'b1);
    tick();
    pc_i = 32'h104; bus.imem_gnt_i = 1'b0; bus.id_ready_i = 1'b0;
    bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hA5A5_0001;
    tick();
    bus.imem_rvalid_i = 1'b0;
    chk("t3_new_valid", bus.id_valid_o, 1'b1);
    chk("t3_new_pc", bus.id_pc_o, 32'h100);
    chk("t3_new_inst", bus.id_inst_o, 32'hA5A5_0001);

    // Flush together with rvalid while the slot is valid.
    bus.imem_gnt_i = 1'b1;
    tick();
    pc_i = 32'h108; bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h7777_7777; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; bus.imem_rvalid_i = 1'b0;
    #1;
    chk("t4_valid", bus.id_valid_o, 1'b0);
    chk("t4_inst", bus.id_inst_o, 32'h0);
    chk("t4_req", bus.imem_req_o, 1'b1);
    chk("t4_addr", bus.imem_addr_o, 32'h108);

    // Reset while WAIT; the stale return afterwards is ignored.
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_valid", bus.id_valid_o, 1'b0);
    chk("t5_pc", bus.id_pc_o, 32'h0);
    chk("t5_pc4", bus.id_pc4_o, 32'h4);
    chk("t5_inst", bus.id_inst_o, 32'h0);
    chk("t5_req", bus.imem_req_o, 1'b1);
    bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h5555_5555;
    tick();
    bus.imem_rvalid_i = 1'b0;
    chk("t5_stale", bus.id_valid_o, 1'b0);

    // PC wrap: id_pc4_o of the last word is zero.
    pc_i = 32'hFFFF_FFFC; bus.imem_gnt_i = 1'b1; bus.id_ready_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0BAD_F00D;
    tick();
    bus.imem_rvalid_i = 1'b0;
    chk("t6_pc", bus.id_pc_o, 32'hFFFF_FFFC);
    chk("t6_pc4", bus.id_pc4_o, 32'h0);
    chk("t6_inst", bus.id_inst_o, 32'h0BAD_F00D);

    // Flush in REQ suppresses request and enable even with a grant.
    pc_i = 32'h200; flush_i = 1'b1; bus.imem_gnt_i = 1'b1;
    #1;
    chk("t7_req", bus.imem_req_o, 1'b0);
    chk("t7_pc_en", pc_en_o, 1'b0);
    tick();
    flush_i = 1'b0; bus.imem_gnt_i = 1'b0;

`ifdef IF_MISALIGN_CHECK_EN
    // Misaligned PC becomes an exception slot without any fetch.
    pc_i = 32'h0000_0102; bus.id_ready_i = 1'b0; bus.imem_gnt_i = 1'b1;
    #1;
    chk("t8_req", bus.imem_req_o, 1'b0);
    chk("t8_pc_en", pc_en_o, 1'b0);
    tick();
    chk("t8_valid", bus.id_valid_o, 1'b1);
    chk("t8_exc", bus.id_exc_o, 1'b1);
    chk("t8_inst", bus.id_inst_o, 32'h0);
    chk("t8_pc", bus.id_pc_o, 32'h0000_0102);
    chk("t8_pc4", bus.id_pc4_o, 32'h0000_0106);
    chk("t8_pc_en2", pc_en_o, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; bus.imem_gnt_i = 1'b0;
    chk("t8_exc_clr", bus.id_exc_o, 1'b0);
    chk("t8_valid_clr", bus.id_valid_o, 1'b0);
`else
    // Low PC bits are not part of the fetch address.
    pc_i = 32'h0000_0102;
    #1;
    chk("t8_addr", bus.imem_addr_o, 32'h0000_0100);
    chk("t8_req", bus.imem_req_o, 1'b1);
`endif

    // Randomized phase against the in-order transaction model.
    clr = 1'b1; bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.id_ready_i = 1'b0;
    tick();
    clr = 1'b0;
    pcreg = 32'h0000_2000; pc_i = pcreg;
    outst = 1'b0; dly = 0; consumed = 0; oaddr = 32'h0;
    for (int cyc = 0; cyc < 640; cyc++) begin
      drain = (cyc >= 600);
      bus.imem_gnt_i = drain ? 1'b0 : 1'($urandom_range(0, 1));
      bus.id_ready_i = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (outst && dly == 0) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i = memw(oaddr);
      end else begin
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = $urandom;
      end
      #1;
      chk("rnd_pc_en", pc_en_o, bus.imem_req_o & bus.imem_gnt_i);
      chk("rnd_one_outstanding", bus.imem_req_o & outst, 1'b0);
      if (bus.imem_req_o) chk("rnd_addr", bus.imem_addr_o, pcreg);
      if (bus.id_valid_o && bus.id_ready_i) begin
        chk("rnd_slot_expected", expq.size() != 0, 1'b1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("rnd_pc", bus.id_pc_o, e.pc);
          chk("rnd_pc4", bus.id_pc4_o, e.pc + 32'd4);
          chk("rnd_inst", bus.id_inst_o, e.inst);
          consumed++;
        end
      end
      if (bus.imem_rvalid_i) begin
        outst = 1'b0;
      end else if (outst && dly > 0) begin
        dly--;
      end
      if (bus.imem_req_o && bus.imem_gnt_i) begin
        expq.push_back('{pc: pcreg, inst: memw(pcreg)});
        oaddr = pcreg;
        pcreg = pcreg + 32'd4;
        outst = 1'b1;
        dly = $urandom_range(0, 3);
      end
      @(posedge clk);
      #1;
      pc_i = pcreg;
    end
    chk("rnd_drained", expq.size(), 32'd0);
    chk("rnd_progress", consumed > 40, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
